// File: rtl/tt_um_counter_checker.sv
// Receive-side checker for a 16-bit free-running counter stream.
// Locks onto the increment-by-one sequence, flywheels once locked, and counts mismatches.
module tt_um_counter_checker #(
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned LOSS_COUNT = 3
) (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
   localparam logic [3:0] LossCnt = 4'(LOSS_COUNT);

   typedef enum logic [1:0] {StSeed, StAcq, StLocked} st_e;

   st_e         st_q, st_d;
   logic [15:0] s_q;
   logic        s_vld_q;
   logic [15:0] exp_q, exp_d;
   logic [3:0]  match_cnt_q, match_cnt_d;
   logic [3:0]  miss_cnt_q, miss_cnt_d;
   logic [4:0]  err_cnt_q, err_cnt_d;
   logic        sticky_q, sticky_d;
   logic        pulse_q, pulse_d;

   logic        match;
   logic [3:0]  match_inc;
   logic [3:0]  miss_inc;
   logic        unused_ena;

   assign unused_ena = ena;
   assign match      = (s_q == exp_q);
   assign match_inc  = match_cnt_q + 4'd1;
   assign miss_inc   = miss_cnt_q + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q         <= '0;
         s_vld_q     <= 1'b0;
         st_q        <= StSeed;
         exp_q       <= '0;
         match_cnt_q <= '0;
         miss_cnt_q  <= '0;
         err_cnt_q   <= '0;
         sticky_q    <= 1'b0;
         pulse_q     <= 1'b0;
      end else begin
         s_q         <= {uio_in, ui_in};
         s_vld_q     <= 1'b1;
         st_q        <= st_d;
         exp_q       <= exp_d;
         match_cnt_q <= match_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         err_cnt_q   <= err_cnt_d;
         sticky_q    <= sticky_d;
         pulse_q     <= pulse_d;
      end
   end

   always_comb begin
      st_d        = st_q;
      exp_d       = exp_q;
      match_cnt_d = match_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      err_cnt_d   = err_cnt_q;
      sticky_d    = sticky_q;
      pulse_d     = 1'b0;
      unique case (st_q)
         StSeed: begin
            if (s_vld_q) begin
               exp_d       = s_q + 16'd1;
               match_cnt_d = '0;
               st_d        = StAcq;
            end
         end
         StAcq: begin
            // Re-seed from the observed value every cycle until enough matches are seen.
            exp_d = s_q + 16'd1;
            if (match) begin
               match_cnt_d = match_inc;
               if (match_inc == LockCnt) begin
                  st_d       = StLocked;
                  miss_cnt_d = '0;
               end
            end else begin
               match_cnt_d = '0;
            end
         end
         StLocked: begin
            // Flywheel: a bad sample costs exactly one mismatch, not a resync.
            exp_d = exp_q + 16'd1;
            if (match) begin
               miss_cnt_d = '0;
            end else begin
               pulse_d    = 1'b1;
               sticky_d   = 1'b1;
               miss_cnt_d = miss_inc;
               if (err_cnt_q != 5'd31) err_cnt_d = err_cnt_q + 5'd1;
               if (miss_inc == LossCnt) begin
                  st_d        = StAcq;
                  match_cnt_d = '0;
                  exp_d       = s_q + 16'd1;
               end
            end
         end
         default: st_d = StSeed;
      endcase
   end

   assign uo_out  = {err_cnt_q, pulse_q, sticky_q, (st_q == StLocked)};
   assign uio_out = '0;
   assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_counter_checker.sv
// Self-checking bench for tt_um_counter_checker: vector table, directed corner
// sequences and a randomized stream compared against a behavioural model.
module tb_tt_um_counter_checker;

   localparam int LOCK = 4;
   localparam int LOSS = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic [7:0] ui_in = '0;
   logic [7:0] uio_in = '0;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks = 0;
   int n_errors = 0;

   tt_um_counter_checker #(
      .LOCK_COUNT(LOCK),
      .LOSS_COUNT(LOSS)
   ) dut (
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe),
      .ena    (ena),
      .clk    (clk),
      .rst_n  (rst_n)
   );

   always #5 clk = ~clk;

   // Behavioural model: one captured sample, a mode, and a single run counter.
   bit          m_have;
   logic [15:0] m_cap;
   int          m_mode;  // 0 seeding, 1 acquiring, 2 locked
   int          m_run;
   logic [15:0] m_exp;
   int          m_err;
   bit          m_sticky;
   bit          m_pulse;

   function automatic logic [7:0] m_uo();
      return {5'(m_err), m_pulse, m_sticky, (m_mode == 2)};
   endfunction

   task automatic model_reset();
      m_have = 0; m_cap = '0; m_mode = 0; m_run = 0; m_exp = '0;
      m_err = 0; m_sticky = 0; m_pulse = 0;
   endtask

   task automatic model_edge(input logic [15:0] v);
      m_pulse = 0;
      if (m_have) begin
         if (m_mode == 0) begin
            m_exp = m_cap + 16'd1; m_run = 0; m_mode = 1;
         end else if (m_mode == 1) begin
            if (m_cap == m_exp) begin
               m_run++;
               if (m_run == LOCK) begin m_mode = 2; m_run = 0; end
            end else m_run = 0;
            m_exp = m_cap + 16'd1;
         end else begin
            if (m_cap == m_exp) begin
               m_run = 0; m_exp = m_exp + 16'd1;
            end else begin
               m_pulse = 1; m_sticky = 1;
               if (m_err < 31) m_err++;
               m_run++;
               if (m_run == LOSS) begin
                  m_mode = 1; m_run = 0; m_exp = m_cap + 16'd1;
               end else m_exp = m_exp + 16'd1;
            end
         end
      end
      m_cap = v;
      m_have = 1;
   endtask

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %02h, want %02h at %0t", name, got, want, $time);
      end
   endtask

   task automatic step(input logic [15:0] v);
      ui_in = v[7:0];
      uio_in = v[15:8];
      @(posedge clk);
      #1;
      model_edge(v);
   endtask

   task automatic step_chk(input logic [15:0] v);
      step(v);
      check("model", uo_out, m_uo());
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [15:0] smp;
      logic [7:0]  uo;
   } vec_t;

   vec_t tbl[7];

   task automatic run_table();
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].smp);
         check($sformatf("clean_lock[%0d]", i), uo_out, tbl[i].uo);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] nxt;
      int          pulses;
      int          r;

      tbl[0] = '{16'h1234, 8'h00};
      tbl[1] = '{16'h1235, 8'h00};
      tbl[2] = '{16'h1236, 8'h00};
      tbl[3] = '{16'h1237, 8'h00};
      tbl[4] = '{16'h1238, 8'h00};
      tbl[5] = '{16'h1239, 8'h01};
      tbl[6] = '{16'h123A, 8'h01};

      // Reset state and clean lock.
      do_reset();
      check("reset_uo", uo_out, 8'h00);
      check("uio_out", uio_out, 8'h00);
      check("uio_oe", uio_oe, 8'h00);
      run_table();
      nxt = 16'h123B;
      for (int i = 0; i < 100; i++) begin
         step(nxt);
         nxt++;
         check("steady", uo_out, 8'h01);
      end

      // Single glitch in place of one good sample.
      pulses = 0;
      step(16'hAAAA); nxt++;
      check("glitch_edge", uo_out, 8'h01);
      for (int i = 0; i < 4; i++) begin
         step(nxt); nxt++;
         if (uo_out[2]) pulses++;
         check("glitch_seq", uo_out, (i == 0) ? 8'h0F : 8'h0B);
      end
      check("glitch_pulses", 8'(pulses), 8'd1);

      // Lock through the 16-bit wrap.
      do_reset();
      nxt = 16'hFFF8;
      for (int i = 0; i < 20; i++) begin
         step_chk(nxt); nxt++;
      end
      check("wrap", uo_out, 8'h01);

      // Loss after three bad samples, then re-lock on a restarted count.
      step_chk(16'hAAAA);
      step_chk(16'h5555);
      step_chk(16'h0F0F);
      step_chk(16'h0000);
      check("loss", uo_out, 8'h1E);
      for (int v = 1; v <= 4; v++) begin
         step_chk(16'(v));
         check("reacq", uo_out, 8'h1A);
      end
      step_chk(16'h0005);
      check("relock", uo_out, 8'h1B);
      nxt = 16'h0006;

      // Saturation: 40 isolated glitches.
      for (int g = 0; g < 40; g++) begin
         step_chk(16'hAAAA); nxt++;
         step_chk(nxt); nxt++;
         step_chk(nxt); nxt++;
      end
      check("saturated", uo_out, 8'hFB);
      step_chk(nxt); nxt++;
      check("sat_hold", uo_out, 8'hFB);

      // Asynchronous reset mid-cycle while locked with errors.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", uo_out, 8'h00);
      do_reset();
      run_table();

      // Randomized stream against the model.
      do_reset();
      nxt = 16'($urandom);
      for (int i = 0; i < 2000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 6) begin
            step_chk(16'($urandom)); nxt++;
         end else if (r < 8) begin
            nxt = 16'($urandom);
            step_chk(nxt); nxt++;
         end else if (r == 8) begin
            for (int k = 0; k < 4; k++) begin
               step_chk(16'($urandom)); nxt++;
            end
         end else begin
            step_chk(nxt); nxt++;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
